hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised pipeline-control unit for the in-order CPU pipeline. It replaces fixed data-hazard detection with a scoreboard of in-flight register writes.
- Tracks every in-flight register write across DEPTH post-decode stages.
- Generates stall/flush controls and per-operand forwarding selects.
- Supports forwarding-enabled and interlock-only modes, and per-instruction result latency.
- Keeps stall statistics counters.
It sits between the decode stage and the stage registers, and drives stall_if, stall_id, flush_id and stall_ex.

Parameters:
DEPTH, 3, number of tracked stages after decode (position 1 = EX output register, DEPTH = last stage before retire)
REG_W, 8, register-index width
FORWARDING, 1, 1 = bypass from stage outputs; 0 = interlock until the writer retires
LAT_W, 2, width of the per-instruction result-latency field
CNT_W, 32, statistics counter width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decode holds a real instruction
issue_r1  in  REG_W  source register 1
issue_r2  in  REG_W  source register 2
issue_use_r1  in  1  source 1 is read
issue_use_r2  in  1  source 2 is read
issue_writes  in  1  instruction writes issue_rw
issue_rw  in  REG_W  destination register
issue_lat  in  LAT_W  position (1..DEPTH) at whose output the result exists
mem_busy  in  1  memory stage cannot accept
issue_ready  out  1  decode instruction advances this cycle
stall_if  out  1  hold fetch
stall_id  out  1  hold decode register
flush_id  out  1  insert bubble into EX
stall_ex  out  1  hold EX register
fwd_sel_r1  out  $clog2(DEPTH+1)  0 = register file, k = position k output
fwd_sel_r2  out  $clog2(DEPTH+1)  same for source 2
hazard_cycles  out  CNT_W  cycles lost to data hazards
busy_cycles  out  CNT_W  cycles lost to mem_busy

Behaviour:
- Scoreboard: entries 1..DEPTH, each holding {valid, writes, rw, lat}.
- Advance rule: when mem_busy=0, each cycle entry[k+1] <= entry[k] and entry[DEPTH] retires (dropped). entry[1] <= the issued instruction if issue_ready=1, else a bubble (valid=0).
- Freeze rule: when mem_busy=1, all entries hold.
- Match per used source: the smallest k with valid & writes & rw==src. The youngest writer wins; older matches are ignored.
- FORWARDING=1:
  - match with k >= lat: fwd_sel=k, no hazard.
  - match with k < lat: hazard.
  - no match: fwd_sel=0.
- FORWARDING=0: any match is a hazard; fwd_sel is always 0. The writer's register-file update at retire is visible to decode in the cycle after entry[DEPTH] drops.
- Unused source (use=0): never hazards; its fwd_sel=0.
- hazard = issue_valid & (hazard_r1 | hazard_r2).
- Outputs, combinational, in priority order:
  1. mem_busy=1: stall_if=stall_id=stall_ex=1, flush_id=0, issue_ready=0.
  2. Else hazard=1: stall_if=1, flush_id=1, stall_id=0, stall_ex=0, issue_ready=0.
  3. Else: all stalls 0, flush_id=0, issue_ready=issue_valid.
- Counters:
  - busy_cycles +1 on each cycle with mem_busy=1.
  - hazard_cycles +1 on each cycle with mem_busy=0 & hazard=1.
  - Both saturate at all-ones and never wrap.
- Reset:
  - All entries invalid and both counters 0 after the first reset edge.
  - While reset=1, all control outputs 0 and fwd_sel 0; mem_busy and issue inputs are ignored.
  - Reset asserted mid-stall abandons the stall. The first cycle after reset sees an empty scoreboard.
- Latency clamp: issue_lat=0 is treated as 1; issue_lat>DEPTH is treated as DEPTH.
- Stall duration: a hazard stall lasts exactly (lat - k) cycles with forwarding, or (DEPTH - k + 1) cycles without, absent mem_busy.

Decomposition:
- Shared package holds:
  - the scoreboard entry typedef {valid, writes, rw, lat}
  - the fwd_sel encoding constant FWD_REGFILE=0
  - the V8/V32 aliases already in common.vh
- One natural sub-module: hazard_match. It is a combinational youngest-match finder, instantiated once per source operand, and returns {hit, k, hazard}.

Test Plan:
1. Reset, then 6 independent ALU ops (distinct rw/sources) -> issue_ready=1 every cycle, all stalls 0, fwd_sel 0, hazard_cycles=0.
2. FORWARDING=1: ALU writes r5 (lat=1), next reads r5 -> fwd_sel_r1=1, no stall. A third instruction reading r5 -> fwd_sel_r1=2.
3. FORWARDING=1: load writes r7 (lat=2), next reads r7 in r2 -> one cycle of stall_if=1, flush_id=1, issue_ready=0. Next cycle fwd_sel_r2=2; hazard_cycles=1.
4. FORWARDING=0, DEPTH=3: write r3, then read r3 -> 3 hazard cycles, then issue with fwd_sel=0; hazard_cycles=3.
5. Writers to r9 at positions 1 (lat 1) and 2, reader of r9 -> fwd_sel=1. Then mem_busy held 4 cycles -> all stalls 1, flush_id=0, scoreboard unchanged, busy_cycles=4, hazard_cycles unchanged.
6. Pending load hazard, reset pulsed 1 cycle -> outputs 0 during reset. Next cycle the same reader issues with no stall; both counters 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared types and constants for the hazard scoreboard slice.
// Revision : 1.0
// ============================================================================
package hazard_scoreboard_pkg;

   localparam int c_reg_w     = 8;
   localparam int c_lat_w     = 2;
   localparam int FWD_REGFILE = 0;

   typedef logic [7:0]  v8_t;
   typedef logic [31:0] v32_t;

   typedef struct packed {
      logic               valid;
      logic               writes;
      logic [c_reg_w-1:0] rw;
      logic [c_lat_w-1:0] lat;
   } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : Decode-side issue bundle with handshake and forwarding selects.
// Revision : 1.0
// ============================================================================
interface hazard_scoreboard_if #(
   parameter int REG_W = 8,
   parameter int LAT_W = 2,
   parameter int SEL_W = 2
);
   logic             issue_valid;
   logic [REG_W-1:0] issue_r1;
   logic [REG_W-1:0] issue_r2;
   logic             issue_use_r1;
   logic             issue_use_r2;
   logic             issue_writes;
   logic [REG_W-1:0] issue_rw;
   logic [LAT_W-1:0] issue_lat;
   logic             issue_ready;
   logic [SEL_W-1:0] fwd_sel_r1;
   logic [SEL_W-1:0] fwd_sel_r2;

   modport master (
      output issue_valid, issue_r1, issue_r2, issue_use_r1, issue_use_r2,
             issue_writes, issue_rw, issue_lat,
      input  issue_ready, fwd_sel_r1, fwd_sel_r2
   );

   modport slave (
      input  issue_valid, issue_r1, issue_r2, issue_use_r1, issue_use_r2,
             issue_writes, issue_rw, issue_lat,
      output issue_ready, fwd_sel_r1, fwd_sel_r2
   );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_hazard_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_match
// Brief    : Finds the youngest in-flight writer of one source register.
// Revision : 1.0
// ============================================================================
module hazard_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int FORWARDING = 1,
   parameter int SEL_W      = 2
) (
   input  sb_entry_t [DEPTH-1:0] entries,
   input  logic [c_reg_w-1:0]    src,
   input  logic                  use_src,
   output logic                  hit,
   output logic [SEL_W-1:0]      k,
   output logic                  hazard
);

   // Scan oldest to youngest so the smallest matching position wins.
   always_comb begin
      hit    = 1'b0;
      k      = '0;
      hazard = 1'b0;
      for (int i = DEPTH; i >= 1; i--) begin
         if (entries[i-1].valid && entries[i-1].writes && entries[i-1].rw == src) begin
            hit    = 1'b1;
            k      = SEL_W'(i);
            hazard = (FORWARDING != 0) ? (i < int'(entries[i-1].lat)) : 1'b1;
         end
      end
      if (!use_src) begin
         hit    = 1'b0;
         k      = '0;
         hazard = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : In-flight write scoreboard driving stall/flush and bypass selects.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int REG_W      = c_reg_w,
   parameter int FORWARDING = 1,
   parameter int LAT_W      = c_lat_w,
   parameter int CNT_W      = 32
) (
   input  logic               clock,
   input  logic               reset,
   hazard_scoreboard_if.slave issue,
   input  logic               mem_busy,
   output logic               stall_if,
   output logic               stall_id,
   output logic               flush_id,
   output logic               stall_ex,
   output logic [CNT_W-1:0]   hazard_cycles,
   output logic [CNT_W-1:0]   busy_cycles
);

   localparam int c_sel_w = $clog2(DEPTH + 1);
   typedef logic [c_sel_w-1:0] sel_t;

   sb_entry_t [DEPTH-1:0] r_sb;
   logic [CNT_W-1:0]      r_hazard_cnt;
   logic [CNT_W-1:0]      r_busy_cnt;

   sb_entry_t        w_new;
   logic [REG_W-1:0] w_rw_in;
   logic [LAT_W-1:0] w_lat_in;
   logic             w_hit_r1, w_hit_r2;
   logic             w_hz_r1, w_hz_r2;
   sel_t             w_k_r1, w_k_r2;
   logic             w_hazard;
   logic             w_issue_ready;

   assign w_rw_in  = issue.issue_rw;
   assign w_lat_in = issue.issue_lat;

   // Out-of-range latencies are clamped so every entry lands in 1..DEPTH.
   always_comb begin
      w_new        = '0;
      w_new.valid  = 1'b1;
      w_new.writes = issue.issue_writes;
      w_new.rw     = w_rw_in;
      if (w_lat_in == '0)
         w_new.lat = c_lat_w'(1);
      else if (int'(w_lat_in) > DEPTH)
         w_new.lat = c_lat_w'(DEPTH);
      else
         w_new.lat = w_lat_in;
   end

   hazard_match #(.DEPTH(DEPTH), .FORWARDING(FORWARDING), .SEL_W(c_sel_w)) u_match_r1 (
      .entries (r_sb),
      .src     (issue.issue_r1),
      .use_src (issue.issue_use_r1),
      .hit     (w_hit_r1),
      .k       (w_k_r1),
      .hazard  (w_hz_r1)
   );

   hazard_match #(.DEPTH(DEPTH), .FORWARDING(FORWARDING), .SEL_W(c_sel_w)) u_match_r2 (
      .entries (r_sb),
      .src     (issue.issue_r2),
      .use_src (issue.issue_use_r2),
      .hit     (w_hit_r2),
      .k       (w_k_r2),
      .hazard  (w_hz_r2)
   );

   assign w_hazard = issue.issue_valid & (w_hz_r1 | w_hz_r2);

   always_comb begin
      stall_if         = 1'b0;
      stall_id         = 1'b0;
      flush_id         = 1'b0;
      stall_ex         = 1'b0;
      w_issue_ready    = 1'b0;
      issue.fwd_sel_r1 = sel_t'(FWD_REGFILE);
      issue.fwd_sel_r2 = sel_t'(FWD_REGFILE);
      if (!reset) begin
         if (w_hit_r1 && !w_hz_r1 && FORWARDING != 0) issue.fwd_sel_r1 = w_k_r1;
         if (w_hit_r2 && !w_hz_r2 && FORWARDING != 0) issue.fwd_sel_r2 = w_k_r2;
         if (mem_busy) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
         end else if (w_hazard) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
         end else begin
            w_issue_ready = issue.issue_valid;
         end
      end
   end

   assign issue.issue_ready = w_issue_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sb         <= '0;
         r_hazard_cnt <= '0;
         r_busy_cnt   <= '0;
      end else if (mem_busy) begin
         if (r_busy_cnt != '1) r_busy_cnt <= r_busy_cnt + CNT_W'(1);
      end else begin
         if (w_hazard && r_hazard_cnt != '1) r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
         for (int i = DEPTH - 1; i >= 1; i--) r_sb[i] <= r_sb[i-1];
         r_sb[0] <= w_issue_ready ? w_new : '0;
      end
   end

   assign hazard_cycles = r_hazard_cnt;
   assign busy_cycles   = r_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Random-stimulus scoreboard bench for forwarding and interlock units.
// Revision : 1.0
// ============================================================================
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int DEPTH = 3;
   localparam int NCYC  = 4000;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset, mem_busy;
   logic       iv[2], iu1[2], iu2[2], iw[2];
   logic [7:0] ir1[2], ir2[2], irw[2];
   logic [1:0] il[2];
   logic       rdy[2], sif[2], sid[2], fid[2], sex[2];
   logic [1:0] sel1[2], sel2[2];
   logic [31:0] hzc0, bzc0;
   logic [3:0]  hzc1, bzc1;

   hazard_scoreboard_if #(.REG_W(8), .LAT_W(2), .SEL_W(2)) bus0 ();
   hazard_scoreboard_if #(.REG_W(8), .LAT_W(2), .SEL_W(2)) bus1 ();

   assign bus0.issue_valid  = iv[0];   assign bus1.issue_valid  = iv[1];
   assign bus0.issue_r1     = ir1[0];  assign bus1.issue_r1     = ir1[1];
   assign bus0.issue_r2     = ir2[0];  assign bus1.issue_r2     = ir2[1];
   assign bus0.issue_use_r1 = iu1[0];  assign bus1.issue_use_r1 = iu1[1];
   assign bus0.issue_use_r2 = iu2[0];  assign bus1.issue_use_r2 = iu2[1];
   assign bus0.issue_writes = iw[0];   assign bus1.issue_writes = iw[1];
   assign bus0.issue_rw     = irw[0];  assign bus1.issue_rw     = irw[1];
   assign bus0.issue_lat    = il[0];   assign bus1.issue_lat    = il[1];
   assign rdy[0]  = bus0.issue_ready;  assign rdy[1]  = bus1.issue_ready;
   assign sel1[0] = bus0.fwd_sel_r1;   assign sel1[1] = bus1.fwd_sel_r1;
   assign sel2[0] = bus0.fwd_sel_r2;   assign sel2[1] = bus1.fwd_sel_r2;

   hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(8), .FORWARDING(1), .LAT_W(2), .CNT_W(32)) u_dut_fwd (
      .clock(clock), .reset(reset), .issue(bus0), .mem_busy(mem_busy),
      .stall_if(sif[0]), .stall_id(sid[0]), .flush_id(fid[0]), .stall_ex(sex[0]),
      .hazard_cycles(hzc0), .busy_cycles(bzc0)
   );

   // Narrow counters so saturation is reached within the run.
   hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(8), .FORWARDING(0), .LAT_W(2), .CNT_W(4)) u_dut_ilk (
      .clock(clock), .reset(reset), .issue(bus1), .mem_busy(mem_busy),
      .stall_if(sif[1]), .stall_id(sid[1]), .flush_id(fid[1]), .stall_ex(sex[1]),
      .hazard_cycles(hzc1), .busy_cycles(bzc1)
   );

   // Reference model: each in-flight writer ages by one per unfrozen cycle.
   typedef struct { logic [7:0] rw; int lat; int pos; } wr_t;
   typedef struct {
      logic rdy, sif, sid, fid, sex;
      logic [1:0] s1, s2;
      longint hz, bz;
   } exp_t;

   wr_t    inflight[2][$];
   exp_t   expq[2][$];
   longint hzm[2], bzm[2], cmax[2];
   logic   p_hz[2], p_rdy[2];
   int     n_cmp = 0;
   int     n_bad = 0;

   function automatic int clamp_lat(input logic [1:0] l);
      if (l == 2'd0) return 1;
      if (int'(l) > DEPTH) return DEPTH;
      return int'(l);
   endfunction

   function automatic void lookup(input int d, input logic [7:0] src, input logic use_s,
                                  output logic hz, output logic [1:0] sel);
      int best;
      int blat;
      hz = 1'b0; sel = 2'd0; best = 0; blat = 0;
      if (!use_s) return;
      foreach (inflight[d][i])
         if (inflight[d][i].rw == src && (best == 0 || inflight[d][i].pos < best)) begin
            best = inflight[d][i].pos;
            blat = inflight[d][i].lat;
         end
      if (best == 0) return;
      if (d == 0 && best >= blat) sel = 2'(best);
      else hz = 1'b1;
   endfunction

   function automatic void model_step(input int d);
      wr_t nq[$];
      wr_t w;
      if (reset) begin
         inflight[d].delete();
         hzm[d] = 0;
         bzm[d] = 0;
      end else if (mem_busy) begin
         if (bzm[d] < cmax[d]) bzm[d]++;
      end else begin
         if (p_hz[d] && hzm[d] < cmax[d]) hzm[d]++;
         foreach (inflight[d][i]) begin
            w = inflight[d][i];
            w.pos++;
            if (w.pos <= DEPTH) nq.push_back(w);
         end
         if (p_rdy[d] && iw[d]) begin
            w.rw = irw[d]; w.lat = clamp_lat(il[d]); w.pos = 1;
            nq.push_back(w);
         end
         inflight[d] = nq;
      end
   endfunction

   function automatic void predict(input int d);
      exp_t e;
      logic h1, h2, hz;
      logic [1:0] s1, s2;
      lookup(d, ir1[d], iu1[d], h1, s1);
      lookup(d, ir2[d], iu2[d], h2, s2);
      hz = iv[d] && (h1 || h2);
      e.rdy = 1'b0; e.sif = 1'b0; e.sid = 1'b0; e.fid = 1'b0; e.sex = 1'b0;
      e.s1 = 2'd0; e.s2 = 2'd0;
      e.hz = hzm[d]; e.bz = bzm[d];
      if (reset) begin
         hz = 1'b0;
      end else begin
         e.s1 = s1; e.s2 = s2;
         if (mem_busy) begin
            e.sif = 1'b1; e.sid = 1'b1; e.sex = 1'b1;
         end else if (hz) begin
            e.sif = 1'b1; e.fid = 1'b1;
         end else begin
            e.rdy = iv[d];
         end
      end
      p_hz[d]  = hz;
      p_rdy[d] = e.rdy;
      expq[d].push_back(e);
   endfunction

   task automatic new_instr(input int d);
      iv[d]  = ($urandom_range(0, 9) != 0);
      ir1[d] = 8'($urandom_range(0, 7));
      ir2[d] = 8'($urandom_range(0, 7));
      iu1[d] = ($urandom_range(0, 3) != 0);
      iu2[d] = ($urandom_range(0, 3) != 0);
      iw[d]  = ($urandom_range(0, 3) != 0);
      irw[d] = 8'($urandom_range(0, 7));
      il[d]  = 2'($urandom_range(0, 3));
   endtask

   function automatic void chk(input string nm, input int d, input logic [63:0] act,
                               input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, d, $time, act, req);
      end
   endfunction

   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         if (expq[d].size() > 0) begin
            exp_t e;
            e = expq[d].pop_front();
            chk("issue_ready", d, 64'(rdy[d]),  64'(e.rdy));
            chk("stall_if",    d, 64'(sif[d]),  64'(e.sif));
            chk("stall_id",    d, 64'(sid[d]),  64'(e.sid));
            chk("flush_id",    d, 64'(fid[d]),  64'(e.fid));
            chk("stall_ex",    d, 64'(sex[d]),  64'(e.sex));
            chk("fwd_sel_r1",  d, 64'(sel1[d]), 64'(e.s1));
            chk("fwd_sel_r2",  d, 64'(sel2[d]), 64'(e.s2));
            chk("hazard_cycles", d, (d == 0) ? 64'(hzc0) : 64'(hzc1), 64'(e.hz));
            chk("busy_cycles",   d, (d == 0) ? 64'(bzc0) : 64'(bzc1), 64'(e.bz));
         end
      end
   end

   initial begin
      cmax[0]  = 64'hFFFF_FFFF;
      cmax[1]  = 15;
      reset    = 1'b1;
      mem_busy = 1'b0;
      for (int d = 0; d < 2; d++) begin
         new_instr(d);
         p_hz[d]  = 1'b0;
         p_rdy[d] = 1'b0;
         hzm[d]   = 0;
         bzm[d]   = 0;
      end
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clock);
         #1;
         for (int d = 0; d < 2; d++) model_step(d);
         reset    = (cyc < 2) || ($urandom_range(0, 99) == 0);
         mem_busy = ($urandom_range(0, 5) == 0);
         // Decode holds a stalled instruction unless it chooses to replace it.
         for (int d = 0; d < 2; d++)
            if (p_rdy[d] || !iv[d] || $urandom_range(0, 15) == 0) new_instr(d);
         for (int d = 0; d < 2; d++) predict(d);
      end
      @(negedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
